// File: rtl/mux_stream_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: selection-mode encodings
// and the channel-slice helper used to pick one channel out of a packed bus.
package mux_stream_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Bit offset of channel idx inside a packed bus of w-bit channels.
    function automatic int unsigned chan_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Rotate-priority arbiter: grants the first requester after `last`, wrapping
// modulo N. Purely combinational so it can be dropped in front of any register.
module rr_arbiter #(
    parameter  int N     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [SEL_W:0] cand;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // last+k stays below 2N, so one conditional subtract implements the wrap.
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N))
                cand = cand - (SEL_W+1)'(N);
            if (!gnt_valid && req[cand[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-input registered stream multiplexer with direct or round-robin selection
// and a single-entry output register that sustains one beat per cycle.
module mux_nto1_stream
    import mux_stream_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [SEL_W-1:0] last;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             direct_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     grant_data;
    logic             free;
    logic             take;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req       (in_valid),
        .last      (last),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Out-of-range selects (possible when N is not a power of two) never grant.
    always_comb begin
        direct_valid = 1'b0;
        if (32'(sel) < 32'(N))
            direct_valid = in_valid[sel];
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = direct_valid;
            grant_idx   = direct_valid ? sel : '0;
        end
    end

    assign grant_data = in_data[chan_lsb(32'(grant_idx), 32'(W)) +: W];
    assign free       = !out_valid || out_ready;
    assign take       = !rst && free && grant_valid;

    always_comb begin
        in_ready = '0;
        if (take)
            in_ready[grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data/channel registers are reset too, so the output is deterministic straight out of reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SEL_W'(N - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            if (mode == MODE_RR)
                last <= grant_idx;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream: directed scenarios plus a randomized
// phase, all compared against a behavioural model of the output beat and pointer.
`timescale 1ns/1ps
module tb_mux_nto1_stream;
    import mux_stream_pkg::*;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int N6 = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [2:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_chan;
    logic           out_valid;
    logic           out_ready;

    logic            mode6;
    logic [2:0]      sel6;
    logic [N6*W-1:0] in_data6;
    logic [N6-1:0]   in_valid6;
    logic [N6-1:0]   in_ready6;
    logic [W-1:0]    out_data6;
    logic [2:0]      out_chan6;
    logic            out_valid6;
    logic            out_ready6;

    int checks = 0;
    int errors = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_last;

    mux_nto1_stream #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_nto1_stream #(.N(N6), .W(W)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
        .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
        .out_ready(out_ready6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference grant: direct picks sel if in range and valid; round-robin picks
    // the valid channel at the smallest circular distance past the last grant.
    function automatic void model_grant(output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (mode == MODE_DIRECT) begin
            if (int'(sel) < N && in_valid[sel]) begin
                ok = 1'b1;
                g  = int'(sel);
            end
        end else begin
            int best;
            best = N;
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && ((i - m_last - 1 + 2*N) % N) < best) begin
                    best = (i - m_last - 1 + 2*N) % N;
                    g    = i;
                    ok   = 1'b1;
                end
            end
        end
    endfunction

    task automatic cycle();
        bit           ok;
        int           g;
        bit           free;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        model_grant(ok, g);
        free    = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && free && ok)
            exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_chan", 64'(out_chan), 64'(m_chan));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_last  = N - 1;
        end else if (free && ok) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_chan  = g;
            if (mode == MODE_RR)
                m_last = g;
        end else if (free) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int seq5[6] = '{1, 4, 7, 1, 4, 7};

        rst       = 1'b1;
        mode      = MODE_RR;
        sel       = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++)
            in_data[i*W +: W] = W'(8'h10 + i);
        mode6      = MODE_DIRECT;
        sel6       = '0;
        in_valid6  = '0;
        out_ready6 = 1'b1;
        for (int i = 0; i < N6; i++)
            in_data6[i*W +: W] = W'(8'h60 + i);

        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_last  = N - 1;

        // Reset held two cycles with every channel valid.
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_data", 64'(out_data), 64'(0));
            check("rst_in_ready", 64'(in_ready), 64'(0));
        end
        rst = 1'b0;
        #1;
        check("rr_first_ready", 64'(in_ready), 64'(8'h01));
        cycle();
        check("rr_first_chan", 64'(out_chan), 64'(0));
        check("rr_first_valid", 64'(out_valid), 64'(1));

        // Direct sweep: one beat per cycle, no bubbles.
        mode = MODE_DIRECT;
        for (int s = 0; s < N; s++) begin
            sel = 3'(s);
            cycle();
            check("dir_valid", 64'(out_valid), 64'(1));
            check("dir_data", 64'(out_data), 64'(8'h10 + s));
            check("dir_chan", 64'(out_chan), 64'(s));
        end

        // Direct select of an idle channel: nothing granted, held beat drains.
        sel      = 3'd3;
        in_valid = 8'hF7;
        #1;
        check("dir_idle_ready", 64'(in_ready), 64'(0));
        cycle();
        check("dir_idle_drain", 64'(out_valid), 64'(0));
        check("dir_idle_hold_data", 64'(out_data), 64'(8'h17));
        check("dir_idle_hold_chan", 64'(out_chan), 64'(7));

        // Six-channel instance: sel=5 is the top legal channel, sel=7 is out of range.
        in_valid6 = '1;
        sel6      = 3'd5;
        cycle();
        check("n6_valid", 64'(out_valid6), 64'(1));
        check("n6_chan", 64'(out_chan6), 64'(5));
        check("n6_data", 64'(out_data6), 64'(8'h65));
        sel6 = 3'd7;
        #1;
        check("n6_oob_ready", 64'(in_ready6), 64'(0));
        cycle();
        check("n6_oob_drain", 64'(out_valid6), 64'(0));
        check("n6_no_x", 64'($isunknown({out_data6, out_chan6, out_valid6, in_ready6})), 64'(0));
        in_valid6 = '0;

        // Round-robin over all channels from a fresh pointer.
        mode     = MODE_RR;
        in_valid = '1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("rr_all_chan", 64'(out_chan), 64'(k % N));
            check("rr_all_data", 64'(out_data), 64'(8'h10 + (k % N)));
        end

        // Sparse round-robin, then a three-cycle stall, then resume.
        in_data  = {$urandom(), $urandom()};
        in_valid = 8'b1001_0010;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_sparse_chan", 64'(out_chan), 64'(seq5[k]));
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_chan", 64'(out_chan), 64'(7));
            check("stall_data", 64'(out_data), 64'(in_data[7*W +: W]));
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        cycle();
        check("resume_chan0", 64'(out_chan), 64'(1));
        cycle();
        check("resume_chan1", 64'(out_chan), 64'(4));

        // Reset while a beat is held under backpressure.
        in_valid = '1;
        do_reset();
        for (int k = 0; k < 3; k++)
            cycle();
        out_ready = 1'b0;
        cycle();
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        cycle();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("post_rst_chan", 64'(out_chan), 64'(k));
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 8'($urandom());
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom()};
            rst       = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
